// File: rtl/crc_word_feeder.sv
// Word-level sequencer that feeds the bit-serial CRC-32 engine from a small FIFO.
// Optional build macro CRC_FEEDER_XOROUT_EN inverts the captured CRC into result.
module crc_word_feeder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic        wr_last,
  output logic        full,
  output logic        overflow,
  input  logic [31:0] cfg_seed,
  input  logic [31:0] cfg_poly,
  output logic        crc_start,
  output logic        crc_reset,
  output logic [31:0] crc_data_in,
  output logic [31:0] crc_orient,
  input  logic        crc_ready,
  input  logic [31:0] crc_data_out,
  output logic [31:0] result,
  output logic        result_valid,
  input  logic        result_ack,
  output logic        busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } entry_t;

  typedef enum logic [2:0] {IDLE, SEED, ISSUE, WAIT, DONE} state_t;

  state_t          state, state_next;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            empty, push, pop;
  logic            last_issued;

  assign empty = (count == CW'(0));
  assign pop   = (state == ISSUE);
  assign push  = wr_en && (!full || pop);
  assign head  = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= entry_t'({wr_last, wr_data});
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_next;
      full     <= (count_next == CW'(DEPTH));
      overflow <= overflow | (wr_en && full && !pop);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!empty && crc_ready) state_next = SEED;
      SEED:    state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (crc_ready) begin
          if (last_issued)  state_next = DONE;
          else if (!empty)  state_next = ISSUE;
        end
      end
      DONE:    if (result_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Engine strobes are registered from the next state so they coincide with SEED/ISSUE.
  always_ff @(posedge CLK) begin
    if (RST) begin
      crc_reset    <= 1'b0;
      crc_start    <= 1'b0;
      crc_data_in  <= '0;
      crc_orient   <= '0;
      last_issued  <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      crc_reset    <= (state_next == SEED);
      crc_start    <= (state_next == ISSUE);
      if (state_next == SEED)       crc_data_in <= cfg_seed;
      else if (state_next == ISSUE) crc_data_in <= head.data;
      else                          crc_data_in <= '0;
      if (state_next == SEED) crc_orient <= cfg_poly;
      if (state == ISSUE) last_issued <= head.last;
      if (state == WAIT && state_next == DONE) begin
`ifdef CRC_FEEDER_XOROUT_EN
        result <= crc_data_out ^ 32'hFFFF_FFFF;
`else
        result <= crc_data_out;
`endif
      end
      result_valid <= (state_next == DONE);
      busy         <= (state_next != IDLE);
    end
  end

endmodule

// File: tb/tb_crc_word_feeder.sv
// Scoreboard bench for crc_word_feeder with a cycle-level model of the bit-serial engine.
module tb_crc_word_feeder;
  localparam int unsigned DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        wr_last;
  logic        full, overflow;
  logic [31:0] cfg_seed, cfg_poly;
  logic        crc_start, crc_reset;
  logic [31:0] crc_data_in, crc_orient;
  logic        crc_ready;
  logic [31:0] crc_data_out;
  logic [31:0] result;
  logic        result_valid;
  logic        result_ack = 1'b0;
  logic        busy;

  crc_word_feeder #(.DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .wr_en(wr_en), .wr_data(wr_data), .wr_last(wr_last),
    .full(full), .overflow(overflow), .cfg_seed(cfg_seed), .cfg_poly(cfg_poly),
    .crc_start(crc_start), .crc_reset(crc_reset), .crc_data_in(crc_data_in),
    .crc_orient(crc_orient), .crc_ready(crc_ready), .crc_data_out(crc_data_out),
    .result(result), .result_valid(result_valid), .result_ack(result_ack), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0, n_err = 0;
  int n_start = 0, n_reset = 0, cyc = 0, seed_cyc = 0, last_lat = 0;
  logic        prev_valid = 1'b0;
  logic [31:0] held;
  logic        ack_en = 1'b0;
  logic [31:0] exp_q[$];

  // Engine: shifts one message bit per cycle for 32 cycles after a start.
  logic [5:0]  eng_cnt;
  logic [31:0] eng_crc, eng_data, eng_poly;
  assign crc_ready    = (eng_cnt == 6'd0);
  assign crc_data_out = eng_crc;

  always @(posedge CLK) begin
    if (RST) begin
      eng_cnt <= 6'd0;
      eng_crc <= 32'h0;
    end else if (eng_cnt != 6'd0) begin
      eng_crc <= {eng_crc[30:0], eng_data[5'(6'd32 - eng_cnt)]} ^ (eng_crc[31] ? eng_poly : 32'h0);
      eng_cnt <= (eng_cnt == 6'd32) ? 6'd0 : eng_cnt + 6'd1;
    end else begin
      if (crc_reset) eng_crc <= crc_data_in;
      if (crc_start) begin
        eng_cnt  <= 6'd1;
        eng_data <= crc_data_in;
        eng_poly <= crc_orient;
      end
    end
  end

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d,
                                           input logic [31:0] p);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int i = 31; i >= 0; i--) begin
      fb = r[31];
      r  = {r[30:0], d[i]};
      if (fb) r = r ^ p;
    end
    return r;
  endfunction

  function automatic logic [31:0] xorout(input logic [31:0] c);
`ifdef CRC_FEEDER_XOROUT_EN
    return c ^ 32'hFFFF_FFFF;
`else
    return c;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each new result.
  always @(negedge CLK) begin
    cyc++;
    if (RST) begin
      prev_valid = 1'b0;
    end else begin
      if (crc_reset) begin
        n_reset++;
        seed_cyc = cyc;
      end
      if (crc_start) n_start++;
      if (crc_start || crc_reset) begin
        check("start_reset_exclusive", 32'(crc_start && crc_reset), 32'd0);
        check("strobe_while_ready", 32'(crc_ready), 32'd1);
      end
      if (result_valid && !prev_valid) begin
        last_lat = cyc - seed_cyc;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_result: got %h expected none", result);
        end else begin
          check("result", result, exp_q.pop_front());
        end
        held = result;
      end else if (result_valid) begin
        check("result_stable", result, held);
      end
      prev_valid = result_valid;
    end
  end

  always @(posedge CLK) begin
    #1;
    result_ack = ack_en && ($urandom_range(0, 2) == 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_raw(input logic [31:0] d, input logic l);
    wr_en = 1'b1; wr_data = d; wr_last = l;
    tick();
    wr_en = 1'b0; wr_last = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l);
    int t = 0;
    while (full && t < 2000) begin tick(); t++; end
    check("push_wait_timeout", 32'(full), 32'd0);
    push_raw(d, l);
  endtask

  task automatic send_msg(input int n, input int max_gap);
    logic [31:0] c, d;
    c = cfg_seed;
    for (int i = 0; i < n; i++) begin
      d = $urandom;
      c = crc_step(c, d, cfg_poly);
      if (i == n - 1) exp_q.push_back(xorout(c));
      push_word(d, i == n - 1);
      repeat ($urandom_range(0, max_gap)) tick();
    end
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while ((busy || result_valid || exp_q.size() != 0) && t < budget) begin tick(); t++; end
    check("idle_timeout", 32'(t >= budget), 32'd0);
  endtask

  task automatic wait_valid(input int budget);
    int t = 0;
    while (!result_valid && t < budget) begin tick(); t++; end
    check("valid_timeout", 32'(result_valid), 32'd1);
  endtask

  task automatic wait_start(input int budget);
    int t = 0;
    while (!crc_start && t < budget) begin tick(); t++; end
    check("start_timeout", 32'(crc_start), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick(); tick();
    exp_q.delete();
    RST = 1'b0;
  endtask

  initial begin
    int s0, r0;
    logic [31:0] w3, c, d, x;
    RST = 1'b1; wr_en = 1'b0; wr_data = '0; wr_last = 1'b0;
    cfg_seed = '0; cfg_poly = '0;
    tick(); tick();
    check("rst_full", 32'(full), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_start", 32'(crc_start), 32'd0);
    check("rst_reset", 32'(crc_reset), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data_in", crc_data_in, 32'd0);
    check("rst_orient", crc_orient, 32'd0);
    check("rst_result", result, 32'd0);
    RST = 1'b0;
    tick();

    // Single-word pass-through with an all-buffer polynomial.
    ack_en = 1'b1;
    cfg_seed = 32'h1234_5678; cfg_poly = 32'h0;
`ifdef CRC_FEEDER_XOROUT_EN
    exp_q.push_back(32'h2152_4110);
`else
    exp_q.push_back(32'hDEAD_BEEF);
`endif
    s0 = n_start; r0 = n_reset;
    push_word(32'hDEAD_BEEF, 1'b1);
    wait_idle(500);
    check("single_latency", 32'(last_lat), 32'd35);
    check("single_starts", 32'(n_start - s0), 32'd1);
    check("single_seeds", 32'(n_reset - r0), 32'd1);

    // Three words with a long gap before the last one.
    cfg_seed = $urandom; cfg_poly = 32'h0;
    s0 = n_start; r0 = n_reset;
    push_word($urandom, 1'b0);
    push_word($urandom, 1'b0);
    repeat (2 * 34 + 50) tick();
    check("gap_busy", 32'(busy), 32'd1);
    check("gap_no_valid", 32'(result_valid), 32'd0);
    check("gap_starts", 32'(n_start - s0), 32'd2);
    w3 = $urandom;
    exp_q.push_back(xorout(w3));
    push_word(w3, 1'b1);
    wait_idle(500);
    check("three_starts", 32'(n_start - s0), 32'd3);
    check("three_seeds", 32'(n_reset - r0), 32'd1);

    // Overflow while result is held, plus backpressure.
    cfg_seed = $urandom; cfg_poly = $urandom;
    ack_en = 1'b0;
    send_msg(1, 0);
    wait_valid(200);
    c = cfg_seed;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      c = crc_step(c, d, cfg_poly);
      push_raw(d, i == DEPTH - 1);
    end
    exp_q.push_back(xorout(c));
    push_raw($urandom, 1'b1);
    check("ovf_full", 32'(full), 32'd1);
    check("ovf_sticky", 32'(overflow), 32'd1);
    r0 = n_reset;
    repeat (100) tick();
    check("hold_no_seed", 32'(n_reset - r0), 32'd0);
    check("hold_valid", 32'(result_valid), 32'd1);
    check("hold_full", 32'(full), 32'd1);
    ack_en = 1'b1;
    wait_idle(1000);
    repeat (60) tick();
    check("dropped_word_idle", 32'(busy), 32'd0);
    check("ovf_persist", 32'(overflow), 32'd1);

    // Push and pop in the same cycle while full.
    do_reset();
    tick();
    check("ovf_cleared", 32'(overflow), 32'd0);
    cfg_seed = $urandom; cfg_poly = $urandom;
    ack_en = 1'b0;
    send_msg(1, 0);
    wait_valid(200);
    c = cfg_seed;
    for (int i = 0; i < DEPTH; i++) begin
      d = $urandom;
      c = crc_step(c, d, cfg_poly);
      push_raw(d, i == DEPTH - 1);
    end
    exp_q.push_back(xorout(c));
    x = $urandom;
    exp_q.push_back(xorout(crc_step(cfg_seed, x, cfg_poly)));
    ack_en = 1'b1;
    wait_start(200);
    check("pp_full_before", 32'(full), 32'd1);
    push_raw(x, 1'b1);
    check("pp_full_after", 32'(full), 32'd1);
    check("pp_no_overflow", 32'(overflow), 32'd0);
    wait_idle(2000);

    // Reset while the engine is busy on a word.
    cfg_seed = $urandom; cfg_poly = $urandom;
    send_msg(2, 0);
    wait_start(100);
    repeat (10) tick();
    RST = 1'b1;
    tick();
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_full", 32'(full), 32'd0);
    check("mid_rst_start", 32'(crc_start), 32'd0);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_result", result, 32'd0);
    exp_q.delete();
    RST = 1'b0;
    s0 = n_start;
    repeat (80) tick();
    check("mid_rst_no_start", 32'(n_start - s0), 32'd0);
    check("mid_rst_idle", 32'(busy), 32'd0);

    // Random batches of back-to-back messages.
    for (int b = 0; b < 3; b++) begin
      cfg_seed = $urandom; cfg_poly = $urandom;
      ack_en = 1'b1;
      for (int m = 0; m < 5; m++) send_msg($urandom_range(1, 4), 3);
      wait_idle(5000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
